tick_scheduler: RTL and testbench

Run/stop/pause controller for the system timebase. It sequences a programmable divider counter and emits one-cycle tick enables instead of a derived clock. Game and FSM logic uses these ticks as clock enables on clk_in. The divisor is reconfigured at runtime through a valid/ready handshake and only takes effect at period boundaries, so a period is never truncated.

---
 rtl/tick_scheduler.sv | 159 +++++++++++++++
 tb/tb_tick_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Run/stop/pause timebase: programmable divider emitting one-cycle tick enables on clk_in.
// Latency: first tick is high in the cycle after edge k+div_q (k = start edge); tick and err_div are registered.
// Backpressure: cfg_ready is high in IDLE and on an unheld RUN boundary, so the divisor only changes between periods.
//
// Ports:
//   clk_in, rst_n             clock (rising edge) and asynchronous active-low reset
//   start, stop, hold         level controls; priority stop > hold > start
//   oneshot                   captured with an accepted start; one tick then back to IDLE
//   cfg_valid/cfg_ready/cfg_div  divisor update handshake; cfg_div < 2 is rejected via err_div
//   tick, busy, state         tick enable pulse, state != IDLE, 00 IDLE / 01 RUN / 10 PAUSE
//   err_div                   one-cycle pulse after a rejected divisor
//   tick_count                ticks since last accepted start; built only when TICK_COUNT_EN is defined,
//                             otherwise tied to 0
module tick_scheduler #(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25000000,
  parameter int TICKS_W     = 16
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic               hold,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  output logic               tick,
  output logic               busy,
  output logic [1:0]         state,
  output logic               err_div,
  output logic [TICKS_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             oneshot_q, oneshot_d;
  logic             tick_d;
  logic             err_d;
  logic             at_bnd;
  logic             cfg_xfer;

  // div_q never drops below 2, so div_q-1 cannot underflow.
  assign at_bnd   = (cnt_q == (div_q - CNT_W'(1)));
  assign cfg_xfer = cfg_valid && cfg_ready;
  assign busy     = (state_q != ST_IDLE);
  assign state    = state_q;

  // Ready only where a new divisor cannot cut a period short.
  always_comb begin
    cfg_ready = 1'b0;
    case (state_q)
      ST_IDLE:  cfg_ready = 1'b1;
      ST_RUN:   cfg_ready = at_bnd && !hold;
      default:  cfg_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    tick_d    = 1'b0;
    err_d     = 1'b0;

    if (cfg_xfer) begin
      if (cfg_div < CNT_W'(2)) begin
        err_d = 1'b1;
      end else begin
        div_d = cfg_div;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          oneshot_d = oneshot;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (stop) begin
          // A boundary coinciding with stop is swallowed: no tick.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (hold) begin
          state_d = ST_PAUSE;
        end else begin
          // Releasing hold counts on the same edge, so the period grows
          // by exactly the number of PAUSE cycles.
          state_d = ST_RUN;
          if (at_bnd) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (oneshot_q) begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      oneshot_q <= 1'b0;
      tick      <= 1'b0;
      err_div   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      tick      <= tick_d;
      err_div   <= err_d;
    end
  end

`ifdef TICK_COUNT_EN
  logic               start_acc;
  logic [TICKS_W-1:0] tick_count_q;

  assign start_acc = (state_q == ST_IDLE) && start && !stop;

  // A start accepted in the same cycle as a trailing tick wins: count restarts at 0.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_count_q <= '0;
    end else if (start_acc) begin
      tick_count_q <= '0;
    end else if (tick) begin
      tick_count_q <= tick_count_q + TICKS_W'(1);
    end
  end

  assign tick_count = tick_count_q;
`else
  assign tick_count = '0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with DEFAULT_DIV=4.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: exercises the cfg handshake at IDLE and at RUN period boundaries.
module tb_tick_scheduler;
  localparam int CNT_W       = 26;
  localparam int DEFAULT_DIV = 4;
  localparam int TICKS_W     = 16;

  logic               clk_in;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               oneshot;
  logic               hold;
  logic               cfg_valid;
  logic [CNT_W-1:0]   cfg_div;
  logic               cfg_ready;
  logic               tick;
  logic               busy;
  logic [1:0]         state;
  logic               err_div;
  logic [TICKS_W-1:0] tick_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_tick;
  logic [31:0] m_aux;

  tick_scheduler #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .TICKS_W    (TICKS_W)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .hold      (hold),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .busy      (busy),
    .state     (state),
    .err_div   (err_div),
    .tick_count(tick_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Bit i-1 of mask is set when tick is high after the i-th edge.
  task automatic run_ticks(input int n, output logic [31:0] mask);
    mask = '0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (tick) mask[i-1] = 1'b1;
    end
  endtask

  task automatic set_div(input int d);
    cfg_div   = CNT_W'(d);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start(input logic os);
    start   = 1'b1;
    oneshot = os;
    step();
    start   = 1'b0;
    oneshot = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    oneshot   = 1'b0;
    hold      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_err_div", 32'(err_div), 32'd0);
    chk("rst_tick_count", 32'(tick_count), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    step();

    // Free-running at the reset divisor.
    do_start(1'b0);
    chk("run_state", 32'(state), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_cfg_ready_cnt0", 32'(cfg_ready), 32'd0);
    run_ticks(12, m_tick);
    chk("run_tick_pattern", m_tick, 32'h888);
    do_stop();
    chk("stop_state", 32'(state), 32'd0);
`ifdef TICK_COUNT_EN
    chk("tick_count_3", 32'(tick_count), 32'd3);
`else
    chk("tick_count_off", 32'(tick_count), 32'd0);
`endif

    // Oneshot: a single tick, IDLE in the same cycle the tick is visible.
    do_start(1'b1);
    chk("tick_count_clr", 32'(tick_count), 32'd0);
    run_ticks(4, m_tick);
    chk("os_first_tick", m_tick, 32'h8);
    chk("os_state_idle", 32'(state), 32'd0);
    chk("os_busy", 32'(busy), 32'd0);
    run_ticks(20, m_tick);
    chk("os_no_more_ticks", m_tick, 32'h0);

    // Divisor change 4 -> 6 requested mid-period; takes effect at the boundary.
    do_start(1'b0);
    m_tick = '0;
    m_aux  = '0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (tick) m_tick[i-1] = 1'b1;
      if (cfg_ready) m_aux[i-1] = 1'b1;
      if (i == 1) begin
        cfg_div   = CNT_W'(6);
        cfg_valid = 1'b1;
      end
      if (i == 4) cfg_valid = 1'b0;
    end
    chk("cfg_tick_4_6_6", m_tick, 32'h8208);
    chk("cfg_ready_bnd", m_aux, 32'h4104);
    do_stop();

    // Rejected divisors: in IDLE and held through RUN boundaries.
    set_div(4);
    chk("div4_no_err", 32'(err_div), 32'd0);
    cfg_div   = CNT_W'(1);
    cfg_valid = 1'b1;
    step();
    chk("idle_err_div", 32'(err_div), 32'd1);
    cfg_valid = 1'b0;
    step();
    chk("idle_err_clear", 32'(err_div), 32'd0);
    do_start(1'b0);
    cfg_div   = CNT_W'(1);
    cfg_valid = 1'b1;
    m_tick = '0;
    m_aux  = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (tick) m_tick[i-1] = 1'b1;
      if (err_div) m_aux[i-1] = 1'b1;
    end
    cfg_valid = 1'b0;
    chk("bad_div_spacing", m_tick, 32'h888);
    chk("bad_div_err_pulses", m_aux, 32'h888);
    do_stop();

    // Hold for 3 cycles at cnt=2 with divisor 5.
    set_div(5);
    do_start(1'b0);
    m_tick = '0;
    m_aux  = '0;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (tick) m_tick[i-1] = 1'b1;
      if (state == 2'b10) m_aux[i-1] = 1'b1;
      if (i == 2) hold = 1'b1;
      if (i == 5) hold = 1'b0;
    end
    chk("hold_tick_8_5_5", m_tick, 32'h21080);
    chk("hold_pause_cycles", m_aux, 32'h1C);
    do_stop();

    // Stop on the boundary cycle swallows the tick and clears cnt.
    set_div(4);
    do_start(1'b0);
    run_ticks(3, m_tick);
    chk("stopb_pre_ticks", m_tick, 32'h0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stopb_no_tick", 32'(tick), 32'd0);
    chk("stopb_state", 32'(state), 32'd0);
    chk("stopb_busy", 32'(busy), 32'd0);
    do_start(1'b0);
    run_ticks(4, m_tick);
    chk("stopb_cnt_cleared", m_tick, 32'h8);
    do_stop();
    start = 1'b1;
    stop  = 1'b1;
    step();
    chk("start_stop_idle", 32'(state), 32'd0);
    start = 1'b0;
    stop  = 1'b0;
    step();
    chk("start_stop_idle2", 32'(state), 32'd0);

    // Asynchronous reset mid-period restores the default divisor.
    set_div(5);
    do_start(1'b0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("arst_err_div", 32'(err_div), 32'd0);
    chk("arst_tick_count", 32'(tick_count), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    do_start(1'b0);
    run_ticks(8, m_tick);
    chk("arst_default_div", m_tick, 32'h88);
    do_stop();
`ifdef TICK_COUNT_EN
    chk("tick_count_2", 32'(tick_count), 32'd2);
`else
    chk("tick_count_off2", 32'(tick_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
